// File: rtl/ihex_loader.sv
// Intel HEX record parser that turns an ASCII character stream into byte writes.
// Optional checksum enforcement: define IHEX_LOADER_CHECKSUM_EN.
module ihex_loader #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_rdy,
    input  logic [7:0]        i_rx_data,
    output logic              o_wr_valid,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    input  logic              i_wr_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [3:0] {
        IDLE,
        COUNT,
        ADDR_HI,
        ADDR_LO,
        TYPE,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic              nib_q, nib_d;
    logic [3:0]        hiNib_q, hiNib_d;
    logic [7:0]        count_q, count_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        type_q, type_d;
    logic [7:0]        sum_q, sum_d;
    logic [15:0]       extHi_q, extHi_d;
    logic [15:0]       extTmp_q, extTmp_d;
    logic              wrValid_q, wrValid_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [7:0]        wrData_q, wrData_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              hexOk;
    logic [3:0]        hexVal;
    logic [7:0]        byteVal;
    logic [7:0]        sumNext;
    logic [15:0]       lowAddr;
    logic [31:0]       fullAddr;
    logic              lastData;
    logic              recordGood;

    // Decode one ASCII hex digit, accepting both letter cases.
    always_comb begin
        hexOk  = 1'b1;
        hexVal = 4'h0;
        if ((i_rx_data >= 8'h30) && (i_rx_data <= 8'h39)) begin
            hexVal = i_rx_data[3:0];
        end else if ((i_rx_data >= 8'h41) && (i_rx_data <= 8'h46)) begin
            hexVal = i_rx_data[3:0] + 4'd9;
        end else if ((i_rx_data >= 8'h61) && (i_rx_data <= 8'h66)) begin
            hexVal = i_rx_data[3:0] + 4'd9;
        end else begin
            hexOk = 1'b0;
        end
    end

    assign byteVal  = {hiNib_q, hexVal};
    assign sumNext  = sum_q + byteVal;
    assign lowAddr  = addr_q + {8'h00, idx_q};
    assign fullAddr = {extHi_q, lowAddr};
    assign lastData = ((idx_q + 8'd1) == count_q);

`ifdef IHEX_LOADER_CHECKSUM_EN
    assign recordGood = (sumNext == 8'h00);
`else
    assign recordGood = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            nib_q     <= 1'b0;
            hiNib_q   <= 4'h0;
            count_q   <= 8'h00;
            addr_q    <= 16'h0000;
            idx_q     <= 8'h00;
            type_q    <= 8'h00;
            sum_q     <= 8'h00;
            extHi_q   <= 16'h0000;
            extTmp_q  <= 16'h0000;
            wrValid_q <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_q     <= nib_d;
            hiNib_q   <= hiNib_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            type_q    <= type_d;
            sum_q     <= sum_d;
            extHi_q   <= extHi_d;
            extTmp_q  <= extTmp_d;
            wrValid_q <= wrValid_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // A pending write always drains, even after the parser has stopped.
    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        hiNib_d   = hiNib_q;
        count_d   = count_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        type_d    = type_q;
        sum_d     = sum_q;
        extHi_d   = extHi_q;
        extTmp_d  = extTmp_q;
        wrValid_d = wrValid_q;
        wrAddr_d  = wrAddr_q;
        wrData_d  = wrData_q;
        done_d    = done_q;
        err_d     = err_q;

        if (wrValid_q && i_wr_ready) begin
            wrValid_d = 1'b0;
        end

        if (i_rx_rdy && (state_q != DONE) && (state_q != ERR)) begin
            if (wrValid_q && !i_wr_ready) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else if (state_q == IDLE) begin
                if (i_rx_data == 8'h3A) begin
                    state_d = COUNT;
                    sum_d   = 8'h00;
                    nib_d   = 1'b0;
                    idx_d   = 8'h00;
                end else if ((i_rx_data != 8'h0D) && (i_rx_data != 8'h0A) &&
                             (i_rx_data != 8'h20)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end else if (!hexOk) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else if (!nib_q) begin
                hiNib_d = hexVal;
                nib_d   = 1'b1;
            end else begin
                nib_d = 1'b0;
                sum_d = sumNext;
                case (state_q)
                    COUNT: begin
                        count_d = byteVal;
                        state_d = ADDR_HI;
                    end
                    ADDR_HI: begin
                        addr_d[15:8] = byteVal;
                        state_d      = ADDR_LO;
                    end
                    ADDR_LO: begin
                        addr_d[7:0] = byteVal;
                        state_d     = TYPE;
                    end
                    TYPE: begin
                        type_d = byteVal;
                        idx_d  = 8'h00;
                        if ((byteVal > 8'h05) ||
                            ((byteVal == 8'h04) && (count_q != 8'h02))) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else if (count_q != 8'h00) begin
                            state_d = DATA;
                        end else begin
                            state_d = CSUM;
                        end
                    end
                    DATA: begin
                        if (type_q == 8'h00) begin
                            wrValid_d = 1'b1;
                            wrAddr_d  = fullAddr[ADDR_W-1:0];
                            wrData_d  = byteVal;
                        end else if (type_q == 8'h04) begin
                            if (idx_q == 8'h00) begin
                                extTmp_d[15:8] = byteVal;
                            end else begin
                                extTmp_d[7:0] = byteVal;
                            end
                        end
                        idx_d = idx_q + 8'd1;
                        if (lastData) begin
                            state_d = CSUM;
                        end
                    end
                    CSUM: begin
                        if (!recordGood) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else if (type_q == 8'h01) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            if (type_q == 8'h04) begin
                                extHi_d = extTmp_q;
                            end
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_busy     = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
    assign o_wr_valid = wrValid_q;
    assign o_wr_addr  = wrAddr_q;
    assign o_wr_data  = wrData_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_ihex_loader.sv
// Directed-vector bench for ihex_loader: records, extended addressing, wrap,
// termination, error paths, overrun and reset.
module tb_ihex_loader;

    logic        clk;
    logic        rstN;
    logic        rxRdy;
    logic [7:0]  rxData;
    logic        wrValid;
    logic [31:0] wrAddr;
    logic [7:0]  wrData;
    logic        wrReady;
    logic        busy;
    logic        done;
    logic        err;

    int passCount;
    int checkCount;

    logic [31:0] wAddr[$];
    logic [7:0]  wData[$];

    ihex_loader #(.ADDR_W(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_rx_rdy   (rxRdy),
        .i_rx_data  (rxData),
        .o_wr_valid (wrValid),
        .o_wr_addr  (wrAddr),
        .o_wr_data  (wrData),
        .i_wr_ready (wrReady),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write that will be accepted on the coming rising edge.
    always @(negedge clk) begin
        if (rstN && wrValid && wrReady) begin
            wAddr.push_back(wrAddr);
            wData.push_back(wrData);
        end
    end

    task automatic sendChar(input logic [7:0] c);
        @(posedge clk);
        #1;
        rxRdy  = 1'b1;
        rxData = c;
        @(posedge clk);
        #1;
        rxRdy = 1'b0;
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) begin
            sendChar(s[i]);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rstN    = 1'b0;
        rxRdy   = 1'b0;
        wrReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        wAddr.delete();
        wData.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checkCount++;
        if ({wrValid, busy, done, err, wrData, wrAddr} !== 44'h0) begin
            $display("[TB] FAIL reset_outputs: got %h expected 0", {wrValid, busy, done, err, wrData, wrAddr});
        end else passCount++;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        sendString(":02000000");
        checkCount++;
        if (busy !== 1'b1) $display("[TB] FAIL busy_mid_record: got %b expected 1", busy);
        else passCount++;
        #2;
        rstN = 1'b0;
        #1;
        checkCount++;
        if ({busy, err, done} !== 3'b000) $display("[TB] FAIL async_reset: got %b expected 000", {busy, err, done});
        else passCount++;
        doReset();
    endtask

    task automatic test_data_record();
        doReset();
        sendString(":0300100011AA55DD\r\n");
        checkCount++;
        if (wAddr.size() !== 3) $display("[TB] FAIL data_write_count: got %0d expected 3", wAddr.size());
        else passCount++;
        checkCount++;
        if (wAddr.size() > 0 && wAddr[0] === 32'h10 && wData[0] === 8'h11) passCount++;
        else $display("[TB] FAIL data_write0: got %0d writes, expected (00000010,11)", wAddr.size());
        checkCount++;
        if (wAddr.size() > 1 && wAddr[1] === 32'h11 && wData[1] === 8'hAA) passCount++;
        else $display("[TB] FAIL data_write1: got %0d writes, expected (00000011,aa)", wAddr.size());
        checkCount++;
        if (wAddr.size() > 2 && wAddr[2] === 32'h12 && wData[2] === 8'h55) passCount++;
        else $display("[TB] FAIL data_write2: got %0d writes, expected (00000012,55)", wAddr.size());
        checkCount++;
        if ({err, busy, done} !== 3'b000) $display("[TB] FAIL data_flags: got %b expected 000", {err, busy, done});
        else passCount++;
    endtask

    task automatic test_ext_addr();
        doReset();
        sendString(":020000040001F9\r\n:01000000AB54\r\n");
        checkCount++;
        if (wAddr.size() == 1 && wAddr[0] === 32'h00010000 && wData[0] === 8'hAB) passCount++;
        else $display("[TB] FAIL ext_addr_write: got %0d writes first %h, expected 1 at 00010000", wAddr.size(), (wAddr.size() > 0) ? wAddr[0] : 32'hx);
        checkCount++;
        if (err !== 1'b0) $display("[TB] FAIL ext_addr_err: got %b expected 0", err);
        else passCount++;
    endtask

    task automatic test_wrap();
        doReset();
        sendString(":02FFFF00AABB9B");
        checkCount++;
        if (wAddr.size() > 0 && wAddr[0] === 32'h0000FFFF && wData[0] === 8'hAA) passCount++;
        else $display("[TB] FAIL wrap_write0: got %0d writes, expected (0000ffff,aa)", wAddr.size());
        checkCount++;
        if (wAddr.size() > 1 && wAddr[1] === 32'h00000000 && wData[1] === 8'hBB) passCount++;
        else $display("[TB] FAIL wrap_write1: got %h expected 00000000", (wAddr.size() > 1) ? wAddr[1] : 32'hx);
    endtask

    task automatic test_eof();
        doReset();
        sendString(":00000001FF");
        checkCount++;
        if ({done, busy, err} !== 3'b100) $display("[TB] FAIL eof_flags: got %b expected 100", {done, busy, err});
        else passCount++;
        sendString(":01000000AB54");
        checkCount++;
        if ({done, busy, err} !== 3'b100 || wAddr.size() !== 0)
            $display("[TB] FAIL eof_terminal: got flags %b writes %0d expected 100 and 0", {done, busy, err}, wAddr.size());
        else passCount++;
    endtask

    task automatic test_checksum();
        logic expErr;
`ifdef IHEX_LOADER_CHECKSUM_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        doReset();
        sendString(":0100000011EF");
        checkCount++;
        if (wAddr.size() == 1 && wData[0] === 8'h11) passCount++;
        else $display("[TB] FAIL csum_write: got %0d writes expected 1 of 11", wAddr.size());
        checkCount++;
        if (err !== expErr) $display("[TB] FAIL csum_err: got %b expected %b", err, expErr);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        doReset();
        sendString(":0100000011EE\r\n:0100010022DC\r\n");
        checkCount++;
        if (wAddr.size() == 2 && wAddr[0] === 32'h0 && wData[0] === 8'h11 &&
            wAddr[1] === 32'h1 && wData[1] === 8'h22 && err === 1'b0) passCount++;
        else $display("[TB] FAIL back_to_back: got %0d writes err %b expected 2 writes err 0", wAddr.size(), err);
    endtask

    task automatic test_ignored_types();
        doReset();
        sendString(":020000021000EC\r\n:01000000ab54\r\n");
        checkCount++;
        if (wAddr.size() == 1 && wAddr[0] === 32'h0 && wData[0] === 8'hAB && err === 1'b0) passCount++;
        else $display("[TB] FAIL type02_lowercase: got %0d writes err %b expected 1 write of ab at 0", wAddr.size(), err);
    endtask

    task automatic test_errors();
        doReset();
        sendString(":0G");
        checkCount++;
        if ({err, busy} !== 2'b10) $display("[TB] FAIL bad_hex: got %b expected 10", {err, busy});
        else passCount++;
        doReset();
        sendString(" x");
        checkCount++;
        if (err !== 1'b1) $display("[TB] FAIL idle_garbage: got %b expected 1", err);
        else passCount++;
        doReset();
        sendString(":00000006FA");
        checkCount++;
        if (err !== 1'b1) $display("[TB] FAIL type06: got %b expected 1", err);
        else passCount++;
        doReset();
        sendString(":0100000400FB");
        checkCount++;
        if (err !== 1'b1) $display("[TB] FAIL type04_count: got %b expected 1", err);
        else passCount++;
        doReset();
        sendString(":0100");
        rstN = 1'b0;
        #3;
        rstN = 1'b1;
        sendString("000011EE");
        checkCount++;
        if (wAddr.size() !== 0 || err !== 1'b1)
            $display("[TB] FAIL reset_abandon: got %0d writes err %b expected 0 writes err 1", wAddr.size(), err);
        else passCount++;
    endtask

    task automatic test_overrun();
        doReset();
        wrReady = 1'b0;
        sendString(":0200000011");
        sendChar("2");
        #1;
        checkCount++;
        if ({err, wrValid, wrAddr, wrData} !== {1'b1, 1'b1, 32'h0, 8'h11})
            $display("[TB] FAIL overrun_hold: got err %b valid %b addr %h data %h expected 1 1 0 11", err, wrValid, wrAddr, wrData);
        else passCount++;
        #2;
        wrReady = 1'b1;
        @(posedge clk);
        #1;
        checkCount++;
        if (wrValid !== 1'b0 || wAddr.size() !== 1)
            $display("[TB] FAIL overrun_drain: got valid %b writes %0d expected 0 and 1", wrValid, wAddr.size());
        else passCount++;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (wAddr.size() !== 1) $display("[TB] FAIL overrun_no_new: got %0d writes expected 1", wAddr.size());
        else passCount++;
        rstN = 1'b0;
        #2;
        checkCount++;
        if ({wrValid, busy, done, err, wrData, wrAddr} !== 44'h0)
            $display("[TB] FAIL overrun_reset: got %h expected 0", {wrValid, busy, done, err, wrData, wrAddr});
        else passCount++;
        rstN = 1'b1;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rstN       = 1'b0;
        rxRdy      = 1'b0;
        rxData     = 8'h00;
        wrReady    = 1'b1;
        test_reset();
        test_data_record();
        test_ext_addr();
        test_wrap();
        test_eof();
        test_checksum();
        test_back_to_back();
        test_ignored_types();
        test_errors();
        test_overrun();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
